// File: rtl/mcb_write_packer.sv
// Packs an upstream byte stream into 32-bit little-endian words and issues
// them to an MCB write-data port, followed by a write command per burst.
//
// state | meaning
// FILL  | assembling bytes, draining the word slot to p0_wr_*
// CMD   | holding p0_cmd_en until the command FIFO accepts the burst
module mcb_write_packer #(
  parameter int unsigned BURST_LEN   = 16,
  parameter logic [29:0] BASE_ADDR   = 30'h0,
  parameter logic [29:0] ADDR_LIMIT  = 30'h0400_0000,
  parameter int unsigned FULL_THRESH = 56
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        flush,
  output logic        wr_full,
  output logic        p0_wr_en,
  output logic [31:0] p0_wr_data,
  output logic [3:0]  p0_wr_mask,
  input  logic        p0_wr_full,
  input  logic [6:0]  p0_wr_count,
  output logic        p0_cmd_en,
  output logic [2:0]  p0_cmd_instr,
  output logic [5:0]  p0_cmd_bl,
  output logic [29:0] p0_cmd_byte_addr,
  input  logic        p0_cmd_full,
  output logic        overflow
);

  localparam logic [6:0] BURST_LEN_W   = 7'(BURST_LEN);
  localparam logic [7:0] FULL_THRESH_W = 8'(FULL_THRESH);
  localparam logic [2:0] INSTR_WRITE   = 3'b000;

  typedef enum logic {ST_FILL = 1'b0, ST_CMD = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_idx;
  logic [31:0] word_buf;
  logic        slot_full;
  logic        slot_last;   // slot word is the final word of a flushed burst
  logic [31:0] slot_data;
  logic [3:0]  slot_mask;
  logic [6:0]  word_cnt;
  logic [5:0]  cmd_bl;
  logic [29:0] addr;
  logic        overflow_q;

  logic        in_fill, wr_fire, cmd_exit;
  logic [31:0] asm_word, new_data;
  logic [2:0]  eff_idx;
  logic [3:0]  pad_mask, new_mask, byte_keep;
  logic        word_done, has_data, flush_take, pad_done, new_word, flush_word;
  logic        slot_free, slot_load, word_drop, mark_last;
  logic        fire_commit, idle_commit, commit;
  logic [6:0]  cmd_words;
  logic [30:0] addr_sum;
  logic [29:0] addr_next;

  assign in_fill  = (state_q == ST_FILL);
  assign wr_fire  = in_fill & slot_full & ~p0_wr_full;
  assign cmd_exit = (state_q == ST_CMD) & ~p0_cmd_full;

  // Current word with this cycle's byte merged in.
  always_comb begin
    asm_word = word_buf;
    if (byte_valid) asm_word[{byte_idx, 3'b000} +: 8] = byte_data;
  end

  assign eff_idx    = {1'b0, byte_idx} + {2'b00, byte_valid};
  assign word_done  = byte_valid & (byte_idx == 2'd3);
  assign has_data   = byte_valid | (byte_idx != 2'd0) | (word_cnt != 7'd0) | slot_full;
  assign flush_take = flush & in_fill & has_data;
  assign pad_done   = flush_take & ~word_done & (eff_idx != 3'd0);
  assign new_word   = word_done | pad_done;
  assign flush_word = flush_take & new_word;

  // Mask marks the unfilled upper bytes of a padded word.
  always_comb begin
    case (eff_idx)
      3'd1:    pad_mask = 4'b1110;
      3'd2:    pad_mask = 4'b1100;
      3'd3:    pad_mask = 4'b1000;
      default: pad_mask = 4'b0000;
    endcase
  end

  assign new_mask  = pad_done ? pad_mask : 4'b0000;
  assign byte_keep = ~new_mask;
  assign new_data  = asm_word & {{8{byte_keep[3]}}, {8{byte_keep[2]}},
                                 {8{byte_keep[1]}}, {8{byte_keep[0]}}};

  // The slot is reloadable in the same cycle it drains, never during CMD.
  assign slot_free = in_fill & (~slot_full | wr_fire);
  assign slot_load = new_word & slot_free;
  assign word_drop = new_word & ~slot_free;
  assign mark_last = flush_take & slot_full & ~wr_fire;

  // A flush with nothing new to add commits on the draining write, or at once
  // when the slot is already empty.
  assign fire_commit = wr_fire & (((word_cnt + 7'd1) == BURST_LEN_W) | slot_last |
                                  (flush_take & ~flush_word));
  assign idle_commit = flush_take & ~flush_word & ~slot_full & (word_cnt != 7'd0);
  assign commit      = fire_commit | idle_commit;

  assign cmd_words = {1'b0, cmd_bl} + 7'd1;
  assign addr_sum  = {1'b0, addr} + {22'd0, cmd_words, 2'b00};
  assign addr_next = (addr_sum >= {1'b0, ADDR_LIMIT}) ? BASE_ADDR : addr_sum[29:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_FILL;
    else        state_q <= state_d;
  end

  // Next state and port strobes.
  always_comb begin
    state_d   = state_q;
    p0_wr_en  = 1'b0;
    p0_cmd_en = 1'b0;
    case (state_q)
      ST_FILL: begin
        p0_wr_en = slot_full;
        if (commit) state_d = ST_CMD;
      end
      ST_CMD: begin
        p0_cmd_en = 1'b1;
        if (!p0_cmd_full) state_d = ST_FILL;
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Byte assembler, word slot, burst counter and address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_buf   <= 32'd0;
      byte_idx   <= 2'd0;
      slot_full  <= 1'b0;
      slot_last  <= 1'b0;
      slot_data  <= 32'd0;
      slot_mask  <= 4'b0000;
      overflow_q <= 1'b0;
      word_cnt   <= 7'd0;
      cmd_bl     <= 6'd0;
      addr       <= BASE_ADDR;
    end else begin
      if (byte_valid) word_buf <= asm_word;

      if (new_word)        byte_idx <= 2'd0;
      else if (byte_valid) byte_idx <= byte_idx + 2'd1;

      if (slot_load) begin
        slot_full <= 1'b1;
        slot_data <= new_data;
        slot_mask <= new_mask;
        slot_last <= flush_word;
      end else if (wr_fire) begin
        slot_full <= 1'b0;
        slot_last <= 1'b0;
      end else if (mark_last) begin
        slot_last <= 1'b1;
      end

      if (word_drop) overflow_q <= 1'b1;

      if (cmd_exit)     word_cnt <= 7'd0;
      else if (wr_fire) word_cnt <= word_cnt + 7'd1;

      if (fire_commit)      cmd_bl <= word_cnt[5:0];
      else if (idle_commit) cmd_bl <= 6'(word_cnt - 7'd1);

      if (cmd_exit) addr <= addr_next;
    end
  end

  assign p0_wr_data       = slot_data;
  assign p0_wr_mask       = slot_mask;
  assign p0_cmd_instr     = INSTR_WRITE;
  assign p0_cmd_bl        = cmd_bl;
  assign p0_cmd_byte_addr = addr;
  assign overflow         = overflow_q;
  assign wr_full          = ({1'b0, p0_wr_count} >= FULL_THRESH_W) | p0_wr_full |
                            (state_q == ST_CMD) | slot_full;

endmodule
